// File: rtl/cpu_tstate_seq_pkg.sv
// Shared definitions for the 6502 cycle sequencer: addressing-mode codes,
// index selectors, per-mode base cycle counts, opcode constants, sequencer
// state encodings and small classification helpers.
package cpu_tstate_seq_pkg;

  typedef logic [4:0] adr_mode_t;

  localparam adr_mode_t ADR_IMPL      = 5'd0;
  localparam adr_mode_t ADR_ACCUM     = 5'd1;
  localparam adr_mode_t ADR_IMM       = 5'd2;
  localparam adr_mode_t ADR_REL       = 5'd3;
  localparam adr_mode_t ADR_ZPG       = 5'd4;
  localparam adr_mode_t ADR_ZPG_RMW   = 5'd5;
  localparam adr_mode_t ADR_ZPG_X_Y   = 5'd6;
  localparam adr_mode_t ADR_ZPG_X_RMW = 5'd7;
  localparam adr_mode_t ADR_ABS       = 5'd8;
  localparam adr_mode_t ADR_ABS_RMW   = 5'd9;
  localparam adr_mode_t ADR_ABS_X_Y   = 5'd10;
  localparam adr_mode_t ADR_ABS_X_RMW = 5'd11;
  localparam adr_mode_t ADR_ABS_X_IND = 5'd12;
  localparam adr_mode_t ADR_ZPG_IND_Y = 5'd13;
  localparam adr_mode_t ADR_ABS_IND   = 5'd14;
  localparam adr_mode_t ADR_STACK_PH  = 5'd15;
  localparam adr_mode_t ADR_STACK_PL  = 5'd16;
  localparam adr_mode_t ADR_STACK_BRK = 5'd17;
  localparam adr_mode_t ADR_ABS_JSR   = 5'd18;
  localparam adr_mode_t ADR_STACK_RTI = 5'd19;
  localparam adr_mode_t ADR_STACK_RTS = 5'd20;
  localparam adr_mode_t ADR_INVAL     = 5'd21;

  localparam logic ADR_INDEX_X = 1'b0;
  localparam logic ADR_INDEX_Y = 1'b1;

  localparam logic [3:0] CYC_IMPL      = 4'd2;
  localparam logic [3:0] CYC_ZPG       = 4'd3;
  localparam logic [3:0] CYC_ZPG_RMW   = 4'd5;
  localparam logic [3:0] CYC_ZPG_X_Y   = 4'd4;
  localparam logic [3:0] CYC_ZPG_X_RMW = 4'd6;
  localparam logic [3:0] CYC_ABS       = 4'd4;
  localparam logic [3:0] CYC_JMP_ABS   = 4'd3;
  localparam logic [3:0] CYC_ABS_RMW   = 4'd6;
  localparam logic [3:0] CYC_ABS_X_Y   = 4'd4;
  localparam logic [3:0] CYC_ABS_X_RMW = 4'd7;
  localparam logic [3:0] CYC_ABS_X_IND = 4'd6;
  localparam logic [3:0] CYC_ZPG_IND_Y = 4'd5;
  localparam logic [3:0] CYC_ABS_IND   = 4'd5;
  localparam logic [3:0] CYC_STACK_PH  = 4'd3;
  localparam logic [3:0] CYC_STACK_PL  = 4'd4;
  localparam logic [3:0] CYC_STACK_BRK = 4'd7;
  localparam logic [3:0] CYC_ABS_JSR   = 4'd6;
  localparam logic [3:0] CYC_STACK_RTI = 4'd6;
  localparam logic [3:0] CYC_STACK_RTS = 4'd6;

  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_DEX     = 8'hCA;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_JAM   = 2'd3;

  // Base length of an instruction; invalid opcodes run as a 2-cycle NOP.
  function automatic logic [3:0] base_cycles(input adr_mode_t mode, input logic [7:0] op);
    case (mode)
      ADR_ZPG:       return CYC_ZPG;
      ADR_ZPG_RMW:   return CYC_ZPG_RMW;
      ADR_ZPG_X_Y:   return CYC_ZPG_X_Y;
      ADR_ZPG_X_RMW: return CYC_ZPG_X_RMW;
      ADR_ABS:       return (op == OP_JMP_ABS) ? CYC_JMP_ABS : CYC_ABS;
      ADR_ABS_RMW:   return CYC_ABS_RMW;
      ADR_ABS_X_Y:   return CYC_ABS_X_Y;
      ADR_ABS_X_RMW: return CYC_ABS_X_RMW;
      ADR_ABS_X_IND: return CYC_ABS_X_IND;
      ADR_ZPG_IND_Y: return CYC_ZPG_IND_Y;
      ADR_ABS_IND:   return CYC_ABS_IND;
      ADR_STACK_PH:  return CYC_STACK_PH;
      ADR_STACK_PL:  return CYC_STACK_PL;
      ADR_STACK_BRK: return CYC_STACK_BRK;
      ADR_ABS_JSR:   return CYC_ABS_JSR;
      ADR_STACK_RTI: return CYC_STACK_RTI;
      ADR_STACK_RTS: return CYC_STACK_RTS;
      default:       return CYC_IMPL;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op[7:5] == 3'b100) && ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  endfunction

  function automatic logic is_rmw(input adr_mode_t mode);
    return (mode == ADR_ZPG_RMW) || (mode == ADR_ZPG_X_RMW) ||
           (mode == ADR_ABS_RMW) || (mode == ADR_ABS_X_RMW);
  endfunction

  function automatic logic has_page_penalty(input adr_mode_t mode);
    return (mode == ADR_ABS_X_Y) || (mode == ADR_ZPG_IND_Y);
  endfunction

endpackage

// File: rtl/cpu_tstate_seq_adr_decode.sv
// Combinational opcode -> addressing-mode / index-register decode for the
// documented 6502 opcode set; everything else decodes as ADR_INVAL.
module cpu_adr_decode
  import cpu_tstate_seq_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [4:0] adr_mode,
  output logic       index
);

  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] c;

  assign a = opcode[7:5];
  assign b = opcode[4:2];
  assign c = opcode[1:0];

  // Decode by opcode group (c), then column (b), then row (a).
  always_comb begin
    adr_mode = ADR_INVAL;
    index    = ADR_INDEX_X;
    case (c)
      2'b01: begin
        case (b)
          3'd0: adr_mode = ADR_ABS_X_IND;
          3'd1: adr_mode = ADR_ZPG;
          3'd2: adr_mode = (a == 3'd4) ? ADR_INVAL : ADR_IMM;
          3'd3: adr_mode = ADR_ABS;
          3'd4: begin adr_mode = ADR_ZPG_IND_Y; index = ADR_INDEX_Y; end
          3'd5: adr_mode = ADR_ZPG_X_Y;
          3'd6: begin adr_mode = ADR_ABS_X_Y; index = ADR_INDEX_Y; end
          default: adr_mode = ADR_ABS_X_Y;
        endcase
      end
      2'b10: begin
        if (a == 3'd4 || a == 3'd5) begin
          // STX / LDX rows index with Y rather than X
          case (b)
            3'd0: adr_mode = (a == 3'd5) ? ADR_IMM : ADR_INVAL;
            3'd1: adr_mode = ADR_ZPG;
            3'd2: adr_mode = ADR_IMPL;
            3'd3: adr_mode = ADR_ABS;
            3'd5: begin adr_mode = ADR_ZPG_X_Y; index = ADR_INDEX_Y; end
            3'd6: adr_mode = ADR_IMPL;
            3'd7: if (a == 3'd5) begin adr_mode = ADR_ABS_X_Y; index = ADR_INDEX_Y; end
            default: adr_mode = ADR_INVAL;
          endcase
        end else begin
          case (b)
            3'd1: adr_mode = ADR_ZPG_RMW;
            3'd2: adr_mode = (opcode == OP_NOP || opcode == OP_DEX) ? ADR_IMPL : ADR_ACCUM;
            3'd3: adr_mode = ADR_ABS_RMW;
            3'd5: adr_mode = ADR_ZPG_X_RMW;
            3'd7: adr_mode = ADR_ABS_X_RMW;
            default: adr_mode = ADR_INVAL;
          endcase
        end
      end
      2'b00: begin
        case (b)
          3'd0: begin
            case (a)
              3'd0: adr_mode = ADR_STACK_BRK;
              3'd1: adr_mode = ADR_ABS_JSR;
              3'd2: adr_mode = ADR_STACK_RTI;
              3'd3: adr_mode = ADR_STACK_RTS;
              3'd4: adr_mode = ADR_INVAL;
              default: adr_mode = ADR_IMM;
            endcase
          end
          3'd1: adr_mode = (a == 3'd1 || a[2]) ? ADR_ZPG : ADR_INVAL;
          3'd2: begin
            if (!a[2]) adr_mode = a[0] ? ADR_STACK_PL : ADR_STACK_PH;
            else       adr_mode = ADR_IMPL;
          end
          3'd3: begin
            case (a)
              3'd0: adr_mode = ADR_INVAL;
              3'd3: adr_mode = ADR_ABS_IND;
              default: adr_mode = ADR_ABS;
            endcase
          end
          3'd4: adr_mode = ADR_REL;
          3'd5: adr_mode = (a == 3'd4 || a == 3'd5) ? ADR_ZPG_X_Y : ADR_INVAL;
          3'd6: adr_mode = ADR_IMPL;
          default: adr_mode = (a == 3'd5) ? ADR_ABS_X_Y : ADR_INVAL;
        endcase
      end
      default: adr_mode = ADR_INVAL;
    endcase
  end

endmodule

// File: rtl/cpu_tstate_seq.sv
// 6502 T-state sequencer: latches IR on sync, registers the addressing-mode
// decode and steps the T-state counter through each instruction, with a
// post-reset sequence, RDY stall and jam on invalid opcodes.
// Optional IRQ injection on the sync cycle is enabled by CPU_IRQ_INJECT_EN.
module cpu_tstate_seq #(
  parameter int T_W            = 3,
  parameter int RESET_CYCLES   = 7,
  parameter bit JAM_ON_INVALID = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic [7:0]     data_in,
  input  logic           page_cross,
  input  logic           branch_taken,
  input  logic           irq_req,
  output logic [7:0]     ir,
  output logic [4:0]     adr_mode,
  output logic           index,
  output logic [T_W-1:0] tstate,
  output logic           sync,
  output logic           last_cycle,
  output logic           rmw_dummy,
  output logic           reset_seq,
  output logic           jammed,
  output logic           int_ack
);
  import cpu_tstate_seq_pkg::*;

  localparam logic [T_W-1:0] T_ONE   = T_W'(1);
  localparam logic [T_W-1:0] T_TWO   = T_W'(2);
  localparam logic [T_W-1:0] T_THREE = T_W'(3);
  localparam logic [T_W-1:0] T_RLAST = T_W'(RESET_CYCLES - 1);

  logic [1:0]     st_q, st_d;
  logic [T_W-1:0] tstate_q, tstate_d;
  logic [7:0]     ir_q, ir_d;
  logic [4:0]     adr_mode_q, adr_mode_d;
  logic           index_q, index_d;

  logic [4:0]     dec_mode;
  logic           dec_index;
  logic [T_W-1:0] base_n;
  logic           lc;
  logic           exec_last;
  logic           irq_take;

  cpu_adr_decode u_adr_decode (
    .opcode   (data_in),
    .adr_mode (dec_mode),
    .index    (dec_index)
  );

`ifdef CPU_IRQ_INJECT_EN
  assign irq_take = (st_q == ST_FETCH) && rdy && irq_req && !rst;
`else
  logic unused_irq;
  assign unused_irq = irq_req;
  assign irq_take   = 1'b0;
`endif

  // End-of-instruction detect, including page-cross and branch extensions.
  always_comb begin
    base_n = T_W'(base_cycles(adr_mode_q, ir_q));
    lc     = 1'b0;
    if (adr_mode_q == ADR_REL) begin
      lc = (tstate_q == T_ONE && !branch_taken) ||
           (tstate_q == T_TWO && !page_cross) ||
           (tstate_q == T_THREE);
    end else if (has_page_penalty(adr_mode_q)) begin
      lc = (tstate_q == base_n - T_ONE && !(is_store(ir_q) || page_cross)) ||
           (tstate_q == base_n);
    end else if (adr_mode_q == ADR_INVAL) begin
      lc = !JAM_ON_INVALID && (tstate_q == T_ONE);
    end else begin
      lc = (tstate_q == base_n - T_ONE);
    end
    exec_last = (st_q == ST_EXEC) && lc;
  end

  // Status outputs derived from the registered state.
  always_comb begin
    ir         = ir_q;
    adr_mode   = adr_mode_q;
    index      = index_q;
    tstate     = tstate_q;
    reset_seq  = rst || (st_q == ST_RESET);
    sync       = !rst && (st_q == ST_FETCH);
    jammed     = !rst && (st_q == ST_JAM);
    last_cycle = !rst && (exec_last || ((st_q == ST_RESET) && (tstate_q == T_RLAST)));
    rmw_dummy  = !rst && (st_q == ST_EXEC) && is_rmw(adr_mode_q) &&
                 (tstate_q == base_n - T_TWO);
    int_ack    = irq_take;
  end

  // Next-state logic; rdy=0 leaves everything as is.
  always_comb begin
    st_d       = st_q;
    tstate_d   = tstate_q;
    ir_d       = ir_q;
    adr_mode_d = adr_mode_q;
    index_d    = index_q;
    if (rdy) begin
      case (st_q)
        ST_RESET: begin
          if (tstate_q == T_RLAST) begin
            st_d     = ST_FETCH;
            tstate_d = '0;
          end else begin
            tstate_d = tstate_q + T_ONE;
          end
        end
        ST_FETCH: begin
          if (irq_take) begin
            ir_d       = OP_BRK;
            adr_mode_d = ADR_STACK_BRK;
            index_d    = ADR_INDEX_X;
          end else begin
            ir_d       = data_in;
            adr_mode_d = dec_mode;
            index_d    = dec_index;
          end
          st_d     = ST_EXEC;
          tstate_d = T_ONE;
        end
        ST_EXEC: begin
          if (exec_last) begin
            st_d     = ST_FETCH;
            tstate_d = '0;
          end else if (JAM_ON_INVALID && adr_mode_q == ADR_INVAL) begin
            st_d = ST_JAM;
          end else begin
            tstate_d = tstate_q + T_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset into the reset sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_RESET;
      tstate_q   <= '0;
      ir_q       <= OP_BRK;
      adr_mode_q <= ADR_STACK_BRK;
      index_q    <= ADR_INDEX_X;
    end else begin
      st_q       <= st_d;
      tstate_q   <= tstate_d;
      ir_q       <= ir_d;
      adr_mode_q <= adr_mode_d;
      index_q    <= index_d;
    end
  end

endmodule

// File: tb/tb_cpu_tstate_seq.sv
// Scoreboard bench for cpu_tstate_seq: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
module tb_cpu_tstate_seq;
  import cpu_tstate_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rdy, page_cross, branch_taken, irq_req;
  logic [7:0] data_in;
  logic [7:0] ir;
  logic [4:0] adr_mode;
  logic       index;
  logic [2:0] tstate;
  logic       sync, last_cycle, rmw_dummy, reset_seq, jammed, int_ack;

  cpu_tstate_seq #(.T_W(3), .RESET_CYCLES(7), .JAM_ON_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .data_in(data_in), .page_cross(page_cross),
    .branch_taken(branch_taken), .irq_req(irq_req), .ir(ir), .adr_mode(adr_mode),
    .index(index), .tstate(tstate), .sync(sync), .last_cycle(last_cycle),
    .rmw_dummy(rmw_dummy), .reset_seq(reset_seq), .jammed(jammed), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [2:0] t;
    logic       sy, la, rm, rs, jm, ak, ci;
    logic [7:0] ir;
    logic [4:0] mode;
    logic       idx;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic [4:0] mode;
    logic       idx;
    int         len;
    int         rmw_at;
    logic [7:0] pc_m;
    logic [7:0] bt_m;
    int         stall_at;
    int         stall_n;
    logic       irq;
    logic       ack;
    logic [7:0] ir_e;
  } instr_t;

  exp_t   sb[$];
  instr_t tbl[$];
  int     n_chk = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each cycle against its pushed expectation.
  always @(negedge clk) begin
    exp_t  e;
    string p;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      p = $sformatf("op%02h.t%0d", e.op, e.t);
      chk({p, ".tstate"},     32'(tstate),     32'(e.t));
      chk({p, ".sync"},       32'(sync),       32'(e.sy));
      chk({p, ".last_cycle"}, 32'(last_cycle), 32'(e.la));
      chk({p, ".rmw_dummy"},  32'(rmw_dummy),  32'(e.rm));
      chk({p, ".reset_seq"},  32'(reset_seq),  32'(e.rs));
      chk({p, ".jammed"},     32'(jammed),     32'(e.jm));
      chk({p, ".int_ack"},    32'(int_ack),    32'(e.ak));
      if (e.ci) begin
        chk({p, ".ir"},       32'(ir),         32'(e.ir));
        chk({p, ".adr_mode"}, 32'(adr_mode),   32'(e.mode));
        chk({p, ".index"},    32'(index),      32'(e.idx));
      end
    end
  end

  task automatic push_exp(input logic [7:0] op, input int t, input logic sy, input logic la,
                          input logic rm, input logic rs, input logic jm, input logic ak,
                          input logic ci, input logic [7:0] ire, input logic [4:0] mo,
                          input logic ix);
    exp_t e;
    e.op = op; e.t = 3'(t); e.sy = sy; e.la = la; e.rm = rm; e.rs = rs; e.jm = jm;
    e.ak = ak; e.ci = ci; e.ir = ire; e.mode = mo; e.idx = ix;
    sb.push_back(e);
  endtask

  function automatic instr_t mk(input logic [7:0] op, input logic [4:0] mode, input logic idx,
                                input int len, input int rmw_at, input logic [7:0] pc_m,
                                input logic [7:0] bt_m, input int stall_at, input int stall_n);
    instr_t d;
    d.op = op; d.mode = mode; d.idx = idx; d.len = len; d.rmw_at = rmw_at;
    d.pc_m = pc_m; d.bt_m = bt_m; d.stall_at = stall_at; d.stall_n = stall_n;
    d.irq = 1'b0; d.ack = 1'b0; d.ir_e = op;
    return d;
  endfunction

  // rst held for `hold` cycles, then the RESET_CYCLES-long reset sequence.
  task automatic do_reset(input int hold, input bit stall_mid);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; rdy = 1'b1; data_in = 8'(($urandom)); irq_req = 1'($urandom);
      page_cross = 1'b0; branch_taken = 1'b0;
      if (i > 0) push_exp(8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00, ADR_STACK_BRK, ADR_INDEX_X);
    end
    for (int k = 0; k < 7; k++) begin
      int reps;
      reps = (stall_mid && k == 3) ? 2 : 1;
      for (int s = 0; s < reps; s++) begin
        @(posedge clk); #1;
        rst = 1'b0; rdy = (s == reps - 1); irq_req = 1'($urandom);
        push_exp(8'h00, k, 0, (k == 6), 0, 1, 0, 0, 1, 8'h00, ADR_STACK_BRK, ADR_INDEX_X);
      end
    end
  endtask

  task automatic run_instr(input instr_t d, input int stop_after);
    for (int k = 0; k < d.len && k < stop_after; k++) begin
      int reps;
      reps = (k == d.stall_at) ? d.stall_n + 1 : 1;
      for (int s = 0; s < reps; s++) begin
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = (s == reps - 1);
        data_in = (k == 0) ? d.op : ~d.op;
        page_cross = d.pc_m[k];
        branch_taken = d.bt_m[k];
        irq_req = (k == 0) ? d.irq : 1'b0;
        push_exp(d.op, k, (k == 0), (k == d.len - 1), (k == d.rmw_at), 0, 0,
                 (k == 0) && d.ack && rdy, (k > 0), d.ir_e, d.mode, d.idx);
      end
    end
  endtask

  initial begin
    instr_t d;
    rst = 1'b1; rdy = 1'b1; data_in = 8'h00; page_cross = 1'b0;
    branch_taken = 1'b0; irq_req = 1'b0;

    tbl.push_back(mk(8'hA5, ADR_ZPG,       ADR_INDEX_X, 3, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hBD, ADR_ABS_X_Y,   ADR_INDEX_X, 5, -1, 8'h08, 8'h00, -1, 0));
    tbl.push_back(mk(8'hBD, ADR_ABS_X_Y,   ADR_INDEX_X, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h9D, ADR_ABS_X_Y,   ADR_INDEX_X, 5, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hD0, ADR_REL,       ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hD0, ADR_REL,       ADR_INDEX_X, 3, -1, 8'h00, 8'h02, -1, 0));
    tbl.push_back(mk(8'hD0, ADR_REL,       ADR_INDEX_X, 4, -1, 8'h04, 8'h02, -1, 0));
    tbl.push_back(mk(8'hEE, ADR_ABS_RMW,   ADR_INDEX_X, 6,  4, 8'h00, 8'h00,  2, 2));
    tbl.push_back(mk(8'hB1, ADR_ZPG_IND_Y, ADR_INDEX_Y, 6, -1, 8'h10, 8'h00, -1, 0));
    tbl.push_back(mk(8'h91, ADR_ZPG_IND_Y, ADR_INDEX_Y, 6, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h4C, ADR_ABS,       ADR_INDEX_X, 3, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h06, ADR_ZPG_RMW,   ADR_INDEX_X, 5,  3, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hF6, ADR_ZPG_X_RMW, ADR_INDEX_X, 6,  4, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h1E, ADR_ABS_X_RMW, ADR_INDEX_X, 7,  5, 8'hFF, 8'h00, -1, 0));
    tbl.push_back(mk(8'h20, ADR_ABS_JSR,   ADR_INDEX_X, 6, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h48, ADR_STACK_PH,  ADR_INDEX_X, 3, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h68, ADR_STACK_PL,  ADR_INDEX_X, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h6C, ADR_ABS_IND,   ADR_INDEX_X, 5, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hA1, ADR_ABS_X_IND, ADR_INDEX_X, 6, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hB6, ADR_ZPG_X_Y,   ADR_INDEX_Y, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h96, ADR_ZPG_X_Y,   ADR_INDEX_Y, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hBC, ADR_ABS_X_Y,   ADR_INDEX_X, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h00, ADR_STACK_BRK, ADR_INDEX_X, 7, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h40, ADR_STACK_RTI, ADR_INDEX_X, 6, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h60, ADR_STACK_RTS, ADR_INDEX_X, 6, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h28, ADR_STACK_PL,  ADR_INDEX_X, 4, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'h0A, ADR_ACCUM,     ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0));
    tbl.push_back(mk(8'hEA, ADR_IMPL,      ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0));
`ifdef CPU_IRQ_INJECT_EN
    d = mk(8'hA9, ADR_STACK_BRK, ADR_INDEX_X, 7, -1, 8'h00, 8'h00, -1, 0);
    d.irq = 1'b1; d.ack = 1'b1; d.ir_e = 8'h00;
`else
    d = mk(8'hA9, ADR_IMM, ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0);
    d.irq = 1'b1;
`endif
    tbl.push_back(d);
    tbl.push_back(mk(8'hA9, ADR_IMM, ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0));

    do_reset(3, 1'b1);
    foreach (tbl[i]) run_instr(tbl[i], 100);

    // reset aborting an instruction midway
    run_instr(mk(8'hBD, ADR_ABS_X_Y, ADR_INDEX_X, 4, -1, 8'h00, 8'h00, -1, 0), 2);
    do_reset(2, 1'b0);
    run_instr(mk(8'hEA, ADR_IMPL, ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0), 100);

    // jam on an invalid opcode; only rst releases it
    @(posedge clk); #1;
    rdy = 1'b1; data_in = 8'h02; irq_req = 1'b0;
    push_exp(8'h02, 0, 1, 0, 0, 0, 0, 0, 0, 8'h02, ADR_INVAL, ADR_INDEX_X);
    @(posedge clk); #1;
    data_in = 8'hEA;
    push_exp(8'h02, 1, 0, 0, 0, 0, 0, 0, 1, 8'h02, ADR_INVAL, ADR_INDEX_X);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      rdy = 1'($urandom); page_cross = 1'($urandom); branch_taken = 1'($urandom);
      irq_req = 1'($urandom); data_in = 8'hEA;
      push_exp(8'h02, 1, 0, 0, 0, 0, 1, 0, 1, 8'h02, ADR_INVAL, ADR_INDEX_X);
    end
    do_reset(2, 1'b0);
    run_instr(mk(8'hEA, ADR_IMPL, ADR_INDEX_X, 2, -1, 8'h00, 8'h00, -1, 0), 100);

    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
